// File: rtl/br_update_queue_pkg.sv
// Shared constants for the branch-update queue and the predictor tables it indexes.
package br_update_queue_pkg;

    localparam int BQ_BIT          = 3;
    localparam int PRED_TABLE_SIZE = 1024;
    localparam int PRED_TABLE_BIT  = $clog2(PRED_TABLE_SIZE);

endpackage

// File: rtl/br_update_queue.sv
// Branch-update queue: holds in-flight branches in program order, records ALU outcomes
// out of order, and retires them in order as predictor-update pulses.
module br_update_queue
    import br_update_queue_pkg::*;
#(
    parameter int BQ_BIT         = br_update_queue_pkg::BQ_BIT,
    parameter int PRED_TABLE_BIT = br_update_queue_pkg::PRED_TABLE_BIT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      alloc_req,
    input  logic [31:0]               alloc_pred,
    input  logic [PRED_TABLE_BIT-1:0] alloc_g_ind,
    input  logic [PRED_TABLE_BIT-1:0] alloc_l_ind,
    output logic [BQ_BIT-1:0]         alloc_tag,
    output logic                      full,
    input  logic                      res_valid,
    input  logic [BQ_BIT-1:0]         res_tag,
    input  logic                      res_taken,
    output logic                      commit_ready,
    input  logic                      commit_req,
    input  logic                      flush_in,
    output logic                      br_req,
    output logic                      br_correct,
    output logic [31:0]               br_res,
    output logic [PRED_TABLE_BIT-1:0] br_g_ind,
    output logic [PRED_TABLE_BIT-1:0] br_l_ind,
    output logic                      mispredict
);

    localparam int DEPTH = 1 << BQ_BIT;
    localparam logic [BQ_BIT:0] DEPTH_CNT = {1'b1, {BQ_BIT{1'b0}}};

    logic [BQ_BIT-1:0] head_reg;
    logic [BQ_BIT-1:0] tail_reg;
    logic [BQ_BIT:0]   count_reg;
    logic [BQ_BIT:0]   count_next;
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  resolved_reg;

    // Payload is never read unless the matching valid bit is set, so it carries no reset.
    logic                      pred_mem   [DEPTH];
    logic                      actual_mem [DEPTH];
    logic [PRED_TABLE_BIT-1:0] g_mem      [DEPTH];
    logic [PRED_TABLE_BIT-1:0] l_mem      [DEPTH];

    logic do_alloc;
    logic do_commit;
    logic do_res;
    logic head_correct;
    logic unused_pred;

    // Only bit 0 of the prediction word carries information.
    assign unused_pred = ^alloc_pred[31:1];

    assign alloc_tag    = tail_reg;
    assign full         = (count_reg == DEPTH_CNT);
    assign commit_ready = valid_reg[head_reg] & resolved_reg[head_reg];
    assign head_correct = (pred_mem[head_reg] == actual_mem[head_reg]);

    assign do_alloc  = rdy_in & ~flush_in & alloc_req & ~full;
    assign do_commit = rdy_in & ~flush_in & commit_req & commit_ready;
    assign do_res    = rdy_in & ~flush_in & res_valid & valid_reg[res_tag];

    always_comb begin
        count_next = count_reg;
        case ({do_alloc, do_commit})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= '0;
            resolved_reg <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_reg     <= '0;
                tail_reg     <= '0;
                count_reg    <= '0;
                valid_reg    <= '0;
                resolved_reg <= '0;
            end else begin
                if (do_res) begin
                    resolved_reg[res_tag] <= 1'b1;
                end
                if (do_commit) begin
                    valid_reg[head_reg]    <= 1'b0;
                    resolved_reg[head_reg] <= 1'b0;
                    head_reg               <= head_reg + 1'b1;
                end
                // Allocation never targets the head slot being popped: that needs full.
                if (do_alloc) begin
                    valid_reg[tail_reg]    <= 1'b1;
                    resolved_reg[tail_reg] <= 1'b0;
                    tail_reg               <= tail_reg + 1'b1;
                end
                count_reg <= count_next;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_res) begin
            actual_mem[res_tag] <= res_taken;
        end
        if (do_alloc) begin
            pred_mem[tail_reg] <= alloc_pred[0];
            g_mem[tail_reg]    <= alloc_g_ind;
            l_mem[tail_reg]    <= alloc_l_ind;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            br_req     <= 1'b0;
            br_correct <= 1'b0;
            br_res     <= '0;
            br_g_ind   <= '0;
            br_l_ind   <= '0;
            mispredict <= 1'b0;
        end else if (rdy_in) begin
            br_req     <= do_commit;
            mispredict <= do_commit & ~head_correct;
            if (do_commit) begin
                br_correct <= head_correct;
                br_res     <= {31'b0, actual_mem[head_reg]};
                br_g_ind   <= g_mem[head_reg];
                br_l_ind   <= l_mem[head_reg];
            end
        end
    end

endmodule

// File: tb/tb_br_update_queue.sv
// Scoreboard bench for br_update_queue: a behavioural queue model predicts every
// commit pulse; a negedge monitor pops and compares each new br_req pulse.
module tb_br_update_queue;

    localparam int DEPTH = 8;
    localparam int BQ    = 3;
    localparam int PB    = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          alloc_req;
    logic [31:0]   alloc_pred;
    logic [PB-1:0] alloc_g_ind;
    logic [PB-1:0] alloc_l_ind;
    logic [BQ-1:0] alloc_tag;
    logic          full;
    logic          res_valid;
    logic [BQ-1:0] res_tag;
    logic          res_taken;
    logic          commit_ready;
    logic          commit_req;
    logic          flush_in;
    logic          br_req;
    logic          br_correct;
    logic [31:0]   br_res;
    logic [PB-1:0] br_g_ind;
    logic [PB-1:0] br_l_ind;
    logic          mispredict;

    br_update_queue dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .alloc_req    (alloc_req),
        .alloc_pred   (alloc_pred),
        .alloc_g_ind  (alloc_g_ind),
        .alloc_l_ind  (alloc_l_ind),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .res_valid    (res_valid),
        .res_tag      (res_tag),
        .res_taken    (res_taken),
        .commit_ready (commit_ready),
        .commit_req   (commit_req),
        .flush_in     (flush_in),
        .br_req       (br_req),
        .br_correct   (br_correct),
        .br_res       (br_res),
        .br_g_ind     (br_g_ind),
        .br_l_ind     (br_l_ind),
        .mispredict   (mispredict)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        bit        correct;
        bit [31:0] res;
        int        g;
        int        l;
        bit        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bit m_valid [DEPTH];
    bit m_resd  [DEPTH];
    bit m_pred  [DEPTH];
    bit m_act   [DEPTH];
    int m_g     [DEPTH];
    int m_l     [DEPTH];
    int m_head, m_tail, m_cnt;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_resd[i]  = 1'b0;
        end
        m_head = 0;
        m_tail = 0;
        m_cnt  = 0;
    endtask

    // One clock: decide acceptance from pre-edge model state, step the model, check status.
    task automatic tick();
        bit rdy_s, flush_s, acc_a, acc_c, acc_r, tk_s;
        bit [31:0] p_s;
        int rt, gs, ls, h;
        exp_t e;
        rdy_s   = rdy_in;
        flush_s = flush_in;
        rt      = int'(res_tag);
        tk_s    = res_taken;
        p_s     = alloc_pred;
        gs      = int'(alloc_g_ind);
        ls      = int'(alloc_l_ind);
        acc_a   = rdy_s && !flush_s && alloc_req && (m_cnt != DEPTH);
        acc_c   = rdy_s && !flush_s && commit_req && m_valid[m_head] && m_resd[m_head];
        acc_r   = rdy_s && !flush_s && res_valid && m_valid[rt];
        @(posedge clk_in);
        #1;
        if (rdy_s && flush_s) begin
            model_clear();
        end else begin
            if (acc_r) begin
                m_resd[rt] = 1'b1;
                m_act[rt]  = tk_s;
            end
            if (acc_c) begin
                h = m_head;
                e.correct = (m_pred[h] == m_act[h]);
                e.res     = {31'b0, m_act[h]};
                e.g       = m_g[h];
                e.l       = m_l[h];
                e.mis     = !e.correct;
                sb.push_back(e);
                m_valid[h] = 1'b0;
                m_resd[h]  = 1'b0;
                m_head     = (m_head + 1) % DEPTH;
                m_cnt--;
            end
            if (acc_a) begin
                m_valid[m_tail] = 1'b1;
                m_resd[m_tail]  = 1'b0;
                m_pred[m_tail]  = p_s[0];
                m_g[m_tail]     = gs;
                m_l[m_tail]     = ls;
                m_tail          = (m_tail + 1) % DEPTH;
                m_cnt++;
            end
        end
        alloc_req  = 1'b0;
        res_valid  = 1'b0;
        commit_req = 1'b0;
        flush_in   = 1'b0;
        check_eq("alloc_tag", 64'(alloc_tag), 64'(m_tail));
        check_eq("full", 64'(full), 64'(m_cnt == DEPTH));
        check_eq("commit_ready", 64'(commit_ready), 64'(m_valid[m_head] && m_resd[m_head]));
    endtask

    task automatic alloc_only(input bit [31:0] p, input int g, input int l);
        alloc_req   = 1'b1;
        alloc_pred  = p;
        alloc_g_ind = PB'(g);
        alloc_l_ind = PB'(l);
        tick();
    endtask

    task automatic resolve_only(input int t, input bit tk);
        res_valid = 1'b1;
        res_tag   = BQ'(t);
        res_taken = tk;
        tick();
    endtask

    task automatic commit_only();
        commit_req = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_br_req"}, 64'(br_req), 64'd0);
        check_eq({pfx, "_br_correct"}, 64'(br_correct), 64'd0);
        check_eq({pfx, "_br_res"}, 64'(br_res), 64'd0);
        check_eq({pfx, "_br_g_ind"}, 64'(br_g_ind), 64'd0);
        check_eq({pfx, "_br_l_ind"}, 64'(br_l_ind), 64'd0);
        check_eq({pfx, "_mispredict"}, 64'(mispredict), 64'd0);
        check_eq({pfx, "_full"}, 64'(full), 64'd0);
        check_eq({pfx, "_commit_ready"}, 64'(commit_ready), 64'd0);
        check_eq({pfx, "_alloc_tag"}, 64'(alloc_tag), 64'd0);
    endtask

    // A new output value is produced only on an edge where rdy_in was high.
    bit rdy_last = 1'b0;
    always @(posedge clk_in) rdy_last = rdy_in;

    always @(negedge clk_in) begin
        if (br_req && rdy_last) begin
            if (sb.size() == 0) begin
                check_eq("br_req_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("br_correct", 64'(br_correct), 64'(mon_e.correct));
                check_eq("br_res", 64'(br_res), 64'(mon_e.res));
                check_eq("br_g_ind", 64'(br_g_ind), 64'(mon_e.g));
                check_eq("br_l_ind", 64'(br_l_ind), 64'(mon_e.l));
                check_eq("mispredict", 64'(mispredict), 64'(mon_e.mis));
                $display("commit g=%0d l=%0d correct=%0b res=%0d mis=%0b",
                         br_g_ind, br_l_ind, br_correct, br_res, mispredict);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_in = 1'b1; rdy_in = 1'b1; alloc_req = 1'b0; alloc_pred = '0;
        alloc_g_ind = '0; alloc_l_ind = '0; res_valid = 1'b0; res_tag = '0;
        res_taken = 1'b0; commit_req = 1'b0; flush_in = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;

        // Correct prediction retires with its indices.
        alloc_only(32'd1, 5, 9);
        resolve_only(0, 1'b1);
        commit_only();
        check_eq("t1_br_req", 64'(br_req), 64'd1);
        tick();
        check_eq("t1_pulse_one_cycle", 64'(br_req), 64'd0);

        // Misprediction.
        alloc_only(32'd1, 3, 4);
        resolve_only(1, 1'b0);
        commit_only();
        check_eq("t2_mispredict", 64'(mispredict), 64'd1);
        tick();

        // Out-of-order resolution, in-order retirement, resolve+alloc same cycle.
        base = m_tail;
        alloc_only(32'd0, 10, 40);
        alloc_only(32'd1, 11, 41);
        alloc_only(32'd1, 12, 42);
        resolve_only((base + 2) % DEPTH, 1'b1);
        commit_req = 1'b1;
        tick();
        check_eq("t3_unresolved_head_no_req", 64'(br_req), 64'd0);
        res_valid = 1'b1; res_tag = BQ'(base); res_taken = 1'b0;
        alloc_req = 1'b1; alloc_pred = 32'd0; alloc_g_ind = PB'(13); alloc_l_ind = PB'(43);
        tick();
        resolve_only((base + 1) % DEPTH, 1'b0);
        repeat (3) commit_only();
        tick();

        // Flush beats a same-cycle commit.
        alloc_only(32'd1, 14, 44);
        alloc_only(32'd0, 15, 45);
        resolve_only(m_head, 1'b1);
        flush_in = 1'b1; commit_req = 1'b1;
        tick();
        check_eq("t4_flush_br_req", 64'(br_req), 64'd0);
        check_eq("t4_flush_tag", 64'(alloc_tag), 64'd0);
        tick();

        // Fill, overflow drop, commit+alloc while full, wrap of the tail.
        for (int i = 0; i < DEPTH; i++) alloc_only(32'(i), i, 100 + i);
        check_eq("t5_full", 64'(full), 64'd1);
        alloc_only(32'd1, 77, 77);
        resolve_only(0, 1'b1);
        commit_req = 1'b1;
        alloc_req = 1'b1; alloc_pred = 32'd1; alloc_g_ind = PB'(88); alloc_l_ind = PB'(88);
        tick();
        alloc_only(32'd1, 90, 90);
        check_eq("t5_wrap_tag", 64'(alloc_tag), 64'd1);
        resolve_only(1, 1'b1);
        commit_only();
        resolve_only(2, 1'b0);
        commit_req = 1'b1;
        alloc_req = 1'b1; alloc_pred = 32'd0; alloc_g_ind = PB'(91); alloc_l_ind = PB'(91);
        tick();
        alloc_only(32'd0, 92, 92);
        flush_in = 1'b1;
        tick();

        // rdy_in low holds everything and does not pop again.
        alloc_only(32'd1, 20, 60);
        alloc_only(32'd1, 21, 61);
        resolve_only(0, 1'b1);
        resolve_only(1, 1'b0);
        commit_only();
        for (int i = 0; i < 3; i++) begin
            rdy_in = 1'b0; commit_req = 1'b1; alloc_req = 1'b1;
            tick();
            check_eq("t6_hold_br_req", 64'(br_req), 64'd1);
            check_eq("t6_hold_g_ind", 64'(br_g_ind), 64'd20);
        end
        rdy_in = 1'b1;
        tick();
        check_eq("t6_released_br_req", 64'(br_req), 64'd0);
        commit_only();
        tick();

        // Asynchronous reset between edges while a pulse is on the outputs.
        alloc_only(32'd1, 30, 70);
        resolve_only(m_head, 1'b1);
        commit_only();
        check_eq("t7_pre_reset_br_req", 64'(br_req), 64'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        model_clear();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        alloc_only(32'd0, 1, 1);
        tick();

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
